// File: rtl/acc_cu_pkg.sv
// Shared encodings for the accumulator control unit: states, opcodes, source selects, ALU ops.
package acc_cu_pkg;

  typedef enum logic [1:0] {StFetch, StDecode, StExecute, StHalt} state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_REG = 2'b01;
  localparam logic [1:0] SEL_IMM = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  // ALU opcodes are contiguous, so the ALU code is the offset from ADD.
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    return is_alu_op(op) ? 3'(op - OP_ADD) : ALU_ADD;
  endfunction

  function automatic logic [1:0] sel_of(input logic [3:0] op);
    if (op == OP_LDI) return SEL_IMM;
    if (op == OP_LDR) return SEL_REG;
    return SEL_ALU;
  endfunction

  function automatic logic loads_acc(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_LDR) || is_alu_op(op);
  endfunction

endpackage

// File: rtl/acc_cu_pc.sv
// Program counter: synchronous reset, branch load overrides increment, wraps naturally.
module acc_cu_pc #(
  parameter int unsigned PC_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else if (load_i) begin
      pc_q <= load_val_i;
    end else if (inc_i) begin
      pc_q <= pc_q + 1'b1;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/acc_control_unit.sv
// Fetch/decode/execute controller for the 8-bit accumulator datapath.
// Define ACC_CU_FETCH_TIMEOUT_EN to halt with fault when a fetch is not acked in time.
module acc_control_unit
  import acc_cu_pkg::*;
#(
  parameter int unsigned PC_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic            clk,
  input  logic            CLB,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic [7:0]      instr_data,
  input  logic            instr_ack,
  input  logic            zero_flag,
  input  logic            carry_flag,
  output logic [2:0]      alu_op,
  output logic [3:0]      reg_addr,
  output logic            reg_we,
  output logic [3:0]      imm,
  output logic [1:0]      SelAcc,
  output logic            loadAcc,
  output logic            halted,
  output logic            fault
);

  state_e     state_q;
  logic [7:0] ir_q;
  logic [3:0] opcode;
  logic       fetch_done;
  logic       waiting;
  logic       taken;
  logic       timeout;

  assign opcode     = ir_q[7:4];
  assign reg_addr   = ir_q[3:0];
  assign imm        = ir_q[3:0];
  assign fetch_done = (state_q == StFetch) && instr_req && instr_ack;
  assign waiting    = (state_q == StFetch) && instr_req && !instr_ack;
  // Flags only matter in EXECUTE; the PC load there overrides the earlier increment.
  assign taken = (state_q == StExecute) &&
                 ((opcode == OP_JMP) ||
                  ((opcode == OP_JZ) && zero_flag) ||
                  ((opcode == OP_JC) && carry_flag));

  acc_cu_pc #(
    .PC_W(PC_W)
  ) u_pc (
    .clk_i      (clk),
    .rst_i      (CLB),
    .inc_i      (fetch_done),
    .load_i     (taken),
    .load_val_i (PC_W'(ir_q[3:0])),
    .pc_o       (instr_addr)
  );

`ifdef ACC_CU_FETCH_TIMEOUT_EN
  localparam int unsigned   CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            fault_q;

  assign timeout = waiting && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (CLB) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q <= waiting ? cnt_q + 1'b1 : '0;
      if (timeout) fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (CLB) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      instr_req <= 1'b0;
      loadAcc   <= 1'b0;
      reg_we    <= 1'b0;
      SelAcc    <= SEL_ALU;
      alu_op    <= ALU_ADD;
      halted    <= 1'b0;
    end else begin
      loadAcc <= 1'b0;
      reg_we  <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (timeout) begin
            state_q   <= StHalt;
            instr_req <= 1'b0;
            halted    <= 1'b1;
          end else if (fetch_done) begin
            ir_q      <= instr_data;
            instr_req <= 1'b0;
            SelAcc    <= sel_of(instr_data[7:4]);
            alu_op    <= alu_of(instr_data[7:4]);
            state_q   <= StDecode;
          end else begin
            instr_req <= 1'b1;
          end
        end
        StDecode: begin
          loadAcc <= loads_acc(opcode);
          reg_we  <= (opcode == OP_STR);
          state_q <= StExecute;
        end
        StExecute: begin
          SelAcc <= SEL_ALU;
          alu_op <= ALU_ADD;
          if (opcode == OP_HLT) begin
            state_q <= StHalt;
            halted  <= 1'b1;
          end else begin
            state_q   <= StFetch;
            instr_req <= 1'b1;
          end
        end
        StHalt: begin
          instr_req <= 1'b0;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule
